// File: rtl/mdpram_arb.sv
// mdpram_arb: round-robin sharing of a 2R/2W read-first RAM among NUM_CLI clients, with zero-fill after reset.
// Optional stall counter enabled by defining MDPRAM_ARB_STATS_EN; otherwise stall_cnt is tied to 0.

module mdpram #(
  parameter int DEPTH  = 1000,
  parameter int WIDTH  = 17,
  parameter int RD_LAT = 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [1:0]                            ren,
  input  logic [1:0][$clog2(DEPTH)-1:0]         raddr,
  output logic [1:0][WIDTH-1:0]                 rdata,
  input  logic [1:0]                            we,
  input  logic [1:0][$clog2(DEPTH)-1:0]         waddr,
  input  logic [1:0][WIDTH-1:0]                 wdata
);
  logic [WIDTH-1:0]                    mem [DEPTH];
  logic [1:0][RD_LAT-1:0][WIDTH-1:0]   rd_pipe;

  // Port 1 is written last, so it would win a same-address collision.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++)
      if (we[p]) mem[waddr[p]] <= wdata[p];
  end

  // Reads sample the array before this edge's writes land (read-first).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_pipe <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (ren[p]) rd_pipe[p][0] <= mem[raddr[p]];
        for (int k = 1; k < RD_LAT; k++) rd_pipe[p][k] <= rd_pipe[p][k-1];
      end
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) rdata[p] = rd_pipe[p][RD_LAT-1];
  end
endmodule

module mdpram_arb_lane #(
  parameter int CW    = 2,
  parameter int WIDTH = 17,
  parameter int ID    = 0
) (
  input  logic [1:0]             tail_vld,
  input  logic [1:0][CW-1:0]     tail_id,
  input  logic [1:0][WIDTH-1:0]  rdata,
  output logic                   rsp_valid,
  output logic [WIDTH-1:0]       rsp_rdata
);
  always_comb begin
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    for (int p = 0; p < 2; p++) begin
      if (tail_vld[p] && tail_id[p] == CW'(ID)) begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata[p];
      end
    end
  end
endmodule

module mdpram_arb #(
  parameter int NUM_CLI = 4,
  parameter int DEPTH   = 1000,
  parameter int WIDTH   = 17,
  parameter int RD_LAT  = 1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NUM_CLI-1:0]                        req_valid,
  output logic [NUM_CLI-1:0]                        req_ready,
  input  logic [NUM_CLI-1:0]                        req_we,
  input  logic [NUM_CLI-1:0][$clog2(DEPTH)-1:0]     req_addr,
  input  logic [NUM_CLI-1:0][WIDTH-1:0]             req_wdata,
  output logic [NUM_CLI-1:0]                        rsp_valid,
  output logic [NUM_CLI-1:0][WIDTH-1:0]             rsp_rdata,
  output logic                                      init_done,
  output logic [31:0]                               stall_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;
  localparam int CW = (NUM_CLI > 1) ? $clog2(NUM_CLI) : 1;

  typedef enum logic {INIT, RUN} state_t;
  typedef struct packed {
    logic             en;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
  } wr_port_t;

  state_t                    state, state_nxt;
  logic [NW-1:0]             cnt, cnt_p1, cnt_p2;
  logic [CW-1:0]             ptr, ptr_nxt;
  wr_port_t [1:0]            wr;
  logic [1:0]                rd_en;
  logic [1:0][AW-1:0]        rd_addr;
  logic [1:0][CW-1:0]        rd_id;
  logic [1:0]                nrd, nwr;
  logic [CW:0]               sum, nx;
  logic [CW-1:0]             c;
  logic [1:0][RD_LAT-1:0]            vld_pipe;
  logic [1:0][RD_LAT-1:0][CW-1:0]    id_pipe;
  logic [1:0]                tail_vld;
  logic [1:0][CW-1:0]        tail_id;
  logic [1:0][WIDTH-1:0]     ram_rdata;
  logic [1:0]                ram_we;
  logic [1:0][AW-1:0]        ram_waddr;
  logic [1:0][WIDTH-1:0]     ram_wdata;

  assign cnt_p1    = cnt + NW'(1);
  assign cnt_p2    = cnt + NW'(2);
  assign init_done = (state == RUN);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    req_ready = '0;
    rd_en     = '0;
    rd_addr   = '0;
    rd_id     = '0;
    wr        = '0;
    nrd       = '0;
    nwr       = '0;
    sum       = '0;
    nx        = '0;
    c         = '0;
    if (state == INIT) begin
      wr[0].en   = 1'b1;
      wr[0].addr = cnt[AW-1:0];
      wr[1].en   = (cnt_p1 < NW'(DEPTH));
      wr[1].addr = cnt_p1[AW-1:0];
      if (cnt_p2 >= NW'(DEPTH)) state_nxt = RUN;
    end else begin
      for (int i = 0; i < NUM_CLI; i++) begin
        sum = {1'b0, ptr} + (CW+1)'(i);
        if (sum >= (CW+1)'(NUM_CLI)) sum = sum - (CW+1)'(NUM_CLI);
        c = sum[CW-1:0];
        if (req_valid[c]) begin
          if (req_we[c]) begin
            if (nwr == 2'd0) begin
              wr[0].en   = 1'b1;
              wr[0].addr = req_addr[c];
              wr[0].data = req_wdata[c];
              nwr        = 2'd1;
              req_ready[c] = 1'b1;
            end else if (nwr == 2'd1 && req_addr[c] != wr[0].addr) begin
              // Same-address loser stays un-granted and retries later.
              wr[1].en   = 1'b1;
              wr[1].addr = req_addr[c];
              wr[1].data = req_wdata[c];
              nwr        = 2'd2;
              req_ready[c] = 1'b1;
            end
          end else begin
            if (nrd == 2'd0) begin
              rd_en[0]   = 1'b1;
              rd_addr[0] = req_addr[c];
              rd_id[0]   = c;
              nrd        = 2'd1;
              req_ready[c] = 1'b1;
            end else if (nrd == 2'd1) begin
              rd_en[1]   = 1'b1;
              rd_addr[1] = req_addr[c];
              rd_id[1]   = c;
              nrd        = 2'd2;
              req_ready[c] = 1'b1;
            end
          end
          if (req_ready[c]) begin
            nx = {1'b0, c} + (CW+1)'(1);
            if (nx >= (CW+1)'(NUM_CLI)) nx = '0;
            ptr_nxt = nx[CW-1:0];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      cnt      <= '0;
      ptr      <= '0;
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) cnt <= cnt_p2;
      ptr <= ptr_nxt;
      for (int p = 0; p < 2; p++) begin
        vld_pipe[p][0] <= rd_en[p];
        id_pipe[p][0]  <= rd_id[p];
        for (int k = 1; k < RD_LAT; k++) begin
          vld_pipe[p][k] <= vld_pipe[p][k-1];
          id_pipe[p][k]  <= id_pipe[p][k-1];
        end
      end
    end
  end

`ifdef MDPRAM_ARB_STATS_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else if (|(req_valid & ~req_ready) && stall_q != '1) stall_q <= stall_q + 32'd1;
  end
  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      tail_vld[p]  = vld_pipe[p][RD_LAT-1];
      tail_id[p]   = id_pipe[p][RD_LAT-1];
      ram_we[p]    = wr[p].en;
      ram_waddr[p] = wr[p].addr;
      ram_wdata[p] = wr[p].data;
    end
  end

  mdpram #(.DEPTH(DEPTH), .WIDTH(WIDTH), .RD_LAT(RD_LAT)) u_ram (
    .clk   (clk),
    .rst_n (~rst),
    .ren   (2'b11),
    .raddr (rd_addr),
    .rdata (ram_rdata),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata)
  );

  for (genvar g = 0; g < NUM_CLI; g++) begin : g_lane
    mdpram_arb_lane #(.CW(CW), .WIDTH(WIDTH), .ID(g)) u_lane (
      .tail_vld  (tail_vld),
      .tail_id   (tail_id),
      .rdata     (ram_rdata),
      .rsp_valid (rsp_valid[g]),
      .rsp_rdata (rsp_rdata[g])
    );
  end
endmodule

// File: tb/tb_mdpram_arb.sv
// Directed bench for mdpram_arb (4 clients, DEPTH 1000, read latency 3).
module tb_mdpram_arb;
  localparam int LAT = 3;
`ifdef MDPRAM_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       req_valid, req_ready, req_we, rsp_valid;
  logic [3:0][9:0]  req_addr;
  logic [3:0][16:0] req_wdata, rsp_rdata;
  logic             init_done;
  logic [31:0]      stall_cnt;
  int               n_assert, n_fail;

  always #5 clk = ~clk;

  mdpram_arb #(.NUM_CLI(4), .DEPTH(1000), .WIDTH(17), .RD_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .init_done(init_done), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic clr();
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic rq(input int c, input bit we, input int addr, input int data);
    req_valid[c] = 1'b1;
    req_we[c]    = we;
    req_addr[c]  = 10'(addr);
    req_wdata[c] = 17'(data);
  endtask

  // Idles LAT cycles after a grant cycle; response must land exactly on the last.
  task automatic rsp_chk(input string tag, input logic [3:0] m, input logic [3:0][16:0] d);
    for (int k = 1; k <= LAT; k++) begin
      cyc(); clr(); #1;
      if (k < LAT) chk({tag, "_early"}, 32'(rsp_valid), 32'd0);
      else begin
        chk({tag, "_vld"}, 32'(rsp_valid), 32'(m));
        for (int c = 0; c < 4; c++)
          if (m[c]) chk({tag, "_data"}, 32'(rsp_rdata[c]), 32'(d[c]));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic bad;
    int   n;
    n_assert = 0; n_fail = 0;
    clr(); rst = 1'b1;
    cyc(); cyc(); #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata[0] | rsp_rdata[1] | rsp_rdata[2] | rsp_rdata[3]), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_stall", stall_cnt, 32'd0);

    // Init sweep with all clients requesting throughout.
    rst = 1'b0; req_valid = 4'hF;
    bad = 1'b0;
    for (int i = 1; i <= 500; i++) begin
      cyc();
      if (i == 500) clr();
      #1;
      if (req_ready != 4'd0) bad = 1'b1;
      if (i == 499) chk("init_499", 32'(init_done), 32'd0);
      if (i == 500) chk("init_500", 32'(init_done), 32'd1);
    end
    chk("init_ready_zero", 32'(bad), 32'd0);
    chk("init_stall", stall_cnt, STATS ? 32'd500 : 32'd0);

    cyc(); rq(0, 0, 999, 0); #1;
    chk("rd999_ready", 32'(req_ready), 32'b0001);
    rsp_chk("rd999", 4'b0001, '0);

    // Parallel access (ptr=1)
    cyc(); clr(); rq(0, 1, 5, 'h1A5); rq(1, 1, 6, 'h0FF); #1;
    chk("par_wr_ready", 32'(req_ready), 32'b0011);
    cyc(); clr(); rq(2, 0, 5, 0); rq(3, 0, 6, 0); #1;
    chk("par_rd_ready", 32'(req_ready), 32'b1100);
    rsp_chk("par", 4'b1100, {17'h0FF, 17'h1A5, 34'h0});

    // Write collision (ptr=0)
    cyc(); clr(); rq(1, 1, 10, 'h111); rq(3, 1, 10, 'h333); #1;
    chk("col_ready1", 32'(req_ready), 32'b0010);
    cyc(); req_valid[1] = 1'b0; #1;
    chk("col_ready2", 32'(req_ready), 32'b1000);
    cyc(); clr(); rq(0, 0, 10, 0); #1;
    chk("col_rd_ready", 32'(req_ready), 32'b0001);
    rsp_chk("col", 4'b0001, {51'h0, 17'h333});

    // Over-subscription (ptr=1): pairs {1,2},{3,0} alternate
    cyc(); clr(); rq(0, 0, 5, 0); rq(1, 0, 6, 0); rq(2, 0, 10, 0); rq(3, 0, 20, 0);
    for (int j = 0; j < 6; j++) begin
      if (j > 0) cyc();
      #1;
      chk("os_ready", 32'(req_ready), (j % 2 == 0) ? 32'b0110 : 32'b1001);
      chk("os_stall", stall_cnt, STATS ? 32'(501 + j) : 32'd0);
      if (j >= LAT) chk("os_rsp", 32'(rsp_valid), ((j - LAT) % 2 == 0) ? 32'b0110 : 32'b1001);
    end
    for (int k = 0; k <= LAT; k++) begin cyc(); clr(); end
    #1;
    chk("os_drained", 32'(rsp_valid), 32'd0);

    // Read-first (ptr=1)
    cyc(); clr(); rq(0, 1, 20, 'h3); #1;
    chk("rf_wr_ready", 32'(req_ready), 32'b0001);
    cyc(); clr(); rq(1, 0, 20, 0); rq(2, 1, 20, 'h7); #1;
    chk("rf_ready", 32'(req_ready), 32'b0110);
    rsp_chk("rf_old", 4'b0010, {34'h0, 17'h3, 17'h0});
    cyc(); clr(); rq(3, 0, 20, 0); #1;
    chk("rf_new_ready", 32'(req_ready), 32'b1000);
    rsp_chk("rf_new", 4'b1000, {17'h7, 51'h0});

    // Reset mid-flight; the top entries are dirtied first so re-init is observable
    cyc(); clr(); rq(0, 1, 998, 'h1ABCD); rq(1, 1, 999, 'h12345); #1;
    chk("mf_wr_ready", 32'(req_ready), 32'b0011);
    cyc(); clr(); rq(2, 0, 999, 0); #1;
    chk("mf_rd_ready", 32'(req_ready), 32'b0100);
    cyc(); clr(); rst = 1'b1; #1;
    chk("mf_rsp_t1", 32'(rsp_valid), 32'd0);
    cyc(); rst = 1'b0; #1;
    chk("mf_init_done", 32'(init_done), 32'd0);
    chk("mf_rsp_t2", 32'(rsp_valid), 32'd0);
    chk("mf_stall", stall_cnt, 32'd0);
    n = 0; bad = 1'b0;
    while (init_done !== 1'b1 && n < 600) begin
      cyc(); n++; #1;
      if (rsp_valid != 4'd0) bad = 1'b1;
    end
    chk("mf_init_cycles", 32'(n), 32'd500);
    chk("mf_no_rsp", 32'(bad), 32'd0);

    // ptr back to 0: clients 1,2 win over 3; re-init zeroed 998/999
    cyc(); clr(); rq(1, 0, 998, 0); rq(2, 0, 999, 0); rq(3, 0, 0, 0); #1;
    chk("reinit_ready", 32'(req_ready), 32'b0110);
    rsp_chk("reinit", 4'b0110, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
